// File: rtl/chnl_regbank_pkg.sv
// chnl_regbank_pkg: word map, response codes, FSM states and the
// address decode shared by the command-channel register bank.
package chnl_regbank_pkg;

    localparam int REG_ID     = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_CTRL   = 2;
    localparam int REG_GP0    = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    typedef struct packed {
        logic       hit;
        logic [5:0] idx;
    } dec_t;

    // Decode on word addresses; byte lane bits never reach here.
    function automatic dec_t addr_decode(
        input logic [29:0] waddr,
        input logic [29:0] wbase,
        input int          num
    );
        dec_t        d;
        logic [29:0] off;
        off   = waddr - wbase;
        d.hit = (waddr >= wbase) && (off < 30'(num));
        d.idx = off[5:0];
        return d;
    endfunction

endpackage

// File: rtl/chnl_regbank.sv
// chnl_regbank: AXI4-Lite slave register bank for the command channel.
// Ports: CHNL_CLK, RST (sync, active-high), cmd_s_axi_* AW/W/B/AR/R
// channels, status_in (live status word), ctrl_pulse (one-cycle strobe),
// reg_out (flattened words, word i at [32*i+31:32*i]).
// Option: define CHNL_REGBANK_WSTRB_EN to honour byte strobes.
module chnl_regbank
    import chnl_regbank_pkg::*;
#(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE  = 32'h5346_444B
) (
    input  logic                  CHNL_CLK,
    input  logic                  RST,
    input  logic                  cmd_s_axi_awvalid,
    output logic                  cmd_s_axi_awready,
    input  logic [31:0]           cmd_s_axi_awaddr,
    input  logic                  cmd_s_axi_wvalid,
    output logic                  cmd_s_axi_wready,
    input  logic [31:0]           cmd_s_axi_wdata,
    input  logic [3:0]            cmd_s_axi_wstrb,
    output logic                  cmd_s_axi_bvalid,
    input  logic                  cmd_s_axi_bready,
    output logic [1:0]            cmd_s_axi_bresp,
    input  logic                  cmd_s_axi_arvalid,
    output logic                  cmd_s_axi_arready,
    input  logic [31:0]           cmd_s_axi_araddr,
    output logic                  cmd_s_axi_rvalid,
    input  logic                  cmd_s_axi_rready,
    output logic [1:0]            cmd_s_axi_rresp,
    output logic [31:0]           cmd_s_axi_rdata,
    input  logic [31:0]           status_in,
    output logic                  ctrl_pulse,
    output logic [32*NUM_REGS-1:0] reg_out
);

    wstate_e     w_state_q, w_state_d;
    logic        aw_vld_q, aw_vld_d;
    logic [29:0] aw_addr_q, aw_addr_d;
    logic        w_vld_q, w_vld_d;
    logic [31:0] w_data_q, w_data_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        pulse_q, pulse_d;
    logic [31:0] rw_q [2:NUM_REGS-1];
    logic [31:0] rw_d [2:NUM_REGS-1];

    rstate_e     r_state_q, r_state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic        aw_hs, w_hs, ar_hs;
    dec_t        wdec, rdec;
    logic [31:0] rd_word;

`ifdef CHNL_REGBANK_WSTRB_EN
    logic [3:0]  w_strb_q, w_strb_d;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] nw,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction
`else
    logic unused_strb;
    assign unused_strb = ^cmd_s_axi_wstrb;
`endif

    logic unused_lsb;
    assign unused_lsb = ^{cmd_s_axi_awaddr[1:0], cmd_s_axi_araddr[1:0]};

    // Ready is forced low while reset is held, not just after it.
    assign cmd_s_axi_awready = !RST && (w_state_q == W_IDLE) && !aw_vld_q;
    assign cmd_s_axi_wready  = !RST && (w_state_q == W_IDLE) && !w_vld_q;
    assign cmd_s_axi_arready = !RST && (r_state_q == R_IDLE);
    assign cmd_s_axi_bvalid  = (w_state_q == W_RESP);
    assign cmd_s_axi_rvalid  = (r_state_q == R_DATA);
    assign cmd_s_axi_bresp   = bresp_q;
    assign cmd_s_axi_rresp   = rresp_q;
    assign cmd_s_axi_rdata   = rdata_q;
    assign ctrl_pulse        = pulse_q;

    assign aw_hs = cmd_s_axi_awvalid && cmd_s_axi_awready;
    assign w_hs  = cmd_s_axi_wvalid && cmd_s_axi_wready;
    assign ar_hs = cmd_s_axi_arvalid && cmd_s_axi_arready;

    assign wdec = addr_decode(aw_addr_q, BASE_ADDR[31:2], NUM_REGS);
    assign rdec = addr_decode(cmd_s_axi_araddr[31:2], BASE_ADDR[31:2],
                              NUM_REGS);

    assign reg_out[31:0]  = ID_VALUE;
    assign reg_out[63:32] = status_in;
    for (genvar g = 2; g < NUM_REGS; g++) begin : g_out
        assign reg_out[32*g +: 32] = rw_q[g];
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_vld_d  = aw_vld_q;
        aw_addr_d = aw_addr_q;
        w_vld_d   = w_vld_q;
        w_data_d  = w_data_q;
        bresp_d   = bresp_q;
        pulse_d   = 1'b0;
        rw_d      = rw_q;
`ifdef CHNL_REGBANK_WSTRB_EN
        w_strb_d  = w_strb_q;
`endif
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_vld_d  = 1'b1;
                    aw_addr_d = cmd_s_axi_awaddr[31:2];
                end
                if (w_hs) begin
                    w_vld_d  = 1'b1;
                    w_data_d = cmd_s_axi_wdata;
`ifdef CHNL_REGBANK_WSTRB_EN
                    w_strb_d = cmd_s_axi_wstrb;
`endif
                end
                if ((aw_vld_q || aw_hs) && (w_vld_q || w_hs))
                    w_state_d = W_COMMIT;
            end
            W_COMMIT: begin
                aw_vld_d  = 1'b0;
                w_vld_d   = 1'b0;
                w_state_d = W_RESP;
                bresp_d   = RESP_SLVERR;
                if (wdec.hit && wdec.idx >= 6'(REG_CTRL)) begin
                    bresp_d = RESP_OKAY;
                    for (int i = 2; i < NUM_REGS; i++) begin
                        if (wdec.idx == 6'(i)) begin
`ifdef CHNL_REGBANK_WSTRB_EN
                            rw_d[i] = merge(rw_q[i], w_data_q, w_strb_q);
`else
                            rw_d[i] = w_data_q;
`endif
                        end
                    end
                    // Strobe bit is never stored, so control reads back 0.
                    if (wdec.idx == 6'(REG_CTRL)) begin
                        rw_d[REG_CTRL][0] = 1'b0;
`ifdef CHNL_REGBANK_WSTRB_EN
                        pulse_d = w_data_q[0] && w_strb_q[0];
`else
                        pulse_d = w_data_q[0];
`endif
                    end
                end
            end
            W_RESP: begin
                if (cmd_s_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        if (rdec.idx == 6'(REG_ID))
            rd_word = ID_VALUE;
        else if (rdec.idx == 6'(REG_STATUS))
            rd_word = status_in;
        for (int i = 2; i < NUM_REGS; i++)
            if (rdec.idx == 6'(i)) rd_word = rw_q[i];
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rdata_d   = rdec.hit ? rd_word : 32'h0;
                    rresp_d   = rdec.hit ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (cmd_s_axi_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge CHNL_CLK) begin
        if (RST) begin
            w_state_q <= W_IDLE;
            aw_vld_q  <= 1'b0;
            aw_addr_q <= '0;
            w_vld_q   <= 1'b0;
            w_data_q  <= '0;
            bresp_q   <= RESP_OKAY;
            pulse_q   <= 1'b0;
            for (int i = 2; i < NUM_REGS; i++) rw_q[i] <= '0;
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
`ifdef CHNL_REGBANK_WSTRB_EN
            w_strb_q  <= '0;
`endif
        end else begin
            w_state_q <= w_state_d;
            aw_vld_q  <= aw_vld_d;
            aw_addr_q <= aw_addr_d;
            w_vld_q   <= w_vld_d;
            w_data_q  <= w_data_d;
            bresp_q   <= bresp_d;
            pulse_q   <= pulse_d;
            rw_q      <= rw_d;
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
`ifdef CHNL_REGBANK_WSTRB_EN
            w_strb_q  <= w_strb_d;
`endif
        end
    end

endmodule

// File: doc/chnl_regbank.md
# chnl_regbank

AXI4-Lite slave register bank that terminates the command channel's AXI4-Lite master port. PC-issued register reads/writes, arriving as AXI4-Lite single-beat transactions, land here. Provides read-only identification and status words, a control word with a self-clearing strobe, and general read/write registers driven out to the user logic. Returns OKAY/SLVERR so the command channel can report errors back to the host.

## Interface
- NUM_REGS, 16, number of 32-bit words; legal range 4..64.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*NUM_REGS rounded up to a power of two.
- ID_VALUE, 32'h5346_444B, constant returned by word 0.

Clock/reset: one clock; reset is synchronous and active-high.
- CHNL_CLK  in  1  sole clock.
- RST  in  1  synchronous active-high reset.
- cmd_s_axi_awvalid/awready  in/out  1  write-address handshake.
- cmd_s_axi_awaddr  in  32  byte address.
- cmd_s_axi_wvalid/wready  in/out  1  write-data handshake.
- cmd_s_axi_wdata  in  32  write data.
- cmd_s_axi_wstrb  in  4  byte strobes.
- cmd_s_axi_bvalid/bready  out/in  1  write-response handshake.
- cmd_s_axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- cmd_s_axi_arvalid/arready  in/out  1  read-address handshake.
- cmd_s_axi_araddr  in  32  byte address.
- cmd_s_axi_rvalid/rready  out/in  1  read-data handshake.
- cmd_s_axi_rresp  out  2  as bresp.
- cmd_s_axi_rdata  out  32  read data.
- status_in  in  32  live status, sampled on read.
- ctrl_pulse  out  1  one-cycle strobe.
- reg_out  out  32*NUM_REGS  flattened register contents, word i at [32*i+31:32*i].

## Operation
- Word map: 0 ID (RO); 1 status_in (RO); 2 control (RW, bit0 self-clearing); 3..NUM_REGS-1 general RW.
- Index = (addr-BASE_ADDR)>>2; addr[1:0] ignored. Out of range when addr<BASE_ADDR or index≥NUM_REGS.
- Write FSM: W_IDLE -> (AW and W captured, in either order or together) W_COMMIT -> W_RESP -> W_IDLE on bvalid&&bready.
- awready=1 while no address is latched and FSM is in W_IDLE. wready=1 while no data is latched and FSM is in W_IDLE.
- Commit: out of range or RO word -> SLVERR, no state change. Otherwise OKAY, register updated.
- Control write with wdata[0]=1 -> ctrl_pulse high exactly one cycle after commit. Stored bit0 reads back 0.
- Read FSM: R_IDLE (arready=1) -> handshake -> R_DATA (rvalid=1, rdata/rresp registered) -> R_IDLE on rready.
- Out of range read -> rdata 0, SLVERR. Read channel and write channel are fully independent.

## Timing
- Reset: awready, wready, arready 0 during reset and 1 in the first cycle after. bvalid, rvalid, ctrl_pulse, bresp, rresp, rdata 0. All RW registers 0; reg_out[63:0] shows ID and status_in.
- AW+W same cycle at edge N -> commit at N+1, bvalid at N+2. reg_out updates visible at N+2.
- AR at edge N -> rvalid/rdata at N+1. arready low until rready handshake.
- bvalid/rvalid held, and data held stable, until accepted; bready stuck low stalls only the write path.
- Read of a word committed in the same cycle returns the pre-write value.
- RST mid-transaction aborts it: pending responses are dropped and latched address/data cleared.

## Configuration
- CHNL_REGBANK_WSTRB_EN defined: only bytes with wstrb[k]=1 are written; wstrb=0 -> OKAY, no change.
- Undefined: wstrb ignored, full 32-bit writes always.

## Structure
- Package chnl_regbank_pkg: word index constants (REG_ID, REG_STATUS, REG_CTRL, REG_GP0), resp codes RESP_OKAY/RESP_SLVERR, FSM state encodings.
- No sub-module; address decode is a function in the package.

## Test plan
- Read 0x0 -> rdata 32'h5346444B, rresp 00, rvalid one cycle after arready handshake.
- AW then W two cycles later to 0xC, data 32'hDEADBEEF -> bresp 00; read 0xC returns DEADBEEF; reg_out[127:96]=DEADBEEF.
- Write 0x4 -> bresp 10, status word unchanged. Read 0x40 with NUM_REGS=16 -> rresp 10, rdata 0.
- Write 0x8 data 1 -> ctrl_pulse high exactly one cycle; read 0x8 -> 0.
- With CHNL_REGBANK_WSTRB_EN: reg 3=DEADBEEF, write 0x11223344 with wstrb 4'b0011 -> reads DEAD3344.
- bready held low 10 cycles with a concurrent read -> read completes, bvalid stays high, awready stays 0 until bready.
